// File: rtl/div_pkg.sv
// Shared definitions for the sequenced restoring divider: state encodings,
// default operand width and the iteration-counter width helper.
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StIter = 2'd1;
    localparam state_t StSign = 2'd2;
    localparam state_t StDone = 2'd3;

    localparam int unsigned DefWidth = 8;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift {A,Qm} left, trial-subtract |M|,
// keep the difference and set the quotient bit only when it did not go negative.
module restoring_div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_qm,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_qm
);

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH:0]   w_t;

    assign w_a_sh = {i_a[WIDTH-2:0], i_qm[WIDTH-1]};
    // Extra MSB of the trial difference is the borrow, i.e. the sign of T.
    assign w_t    = {1'b0, w_a_sh} - {1'b0, i_m};
    assign o_a    = w_t[WIDTH] ? w_a_sh : w_t[WIDTH-1:0];
    assign o_qm   = {i_qm[WIDTH-2:0], ~w_t[WIDTH]};

endmodule

// File: rtl/restoring_div_seq_ctrl.sv
// Multi-cycle signed restoring divider: magnitudes are divided one bit per clock,
// signs are applied in a final pass and the result is presented with a done pulse.
module restoring_div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    state_t           r_state;
    state_t           w_state_d;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_qm;
    logic [WIDTH-1:0] r_m;
    logic             r_q_neg;
    logic             r_m_neg;
    logic             r_ovf_pend;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic             r_ovf;
    logic             w_busy_d;
    logic             w_done_d;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_qm_nxt;

    restoring_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a  (r_a),
        .i_qm (r_qm),
        .i_m  (r_m),
        .o_a  (w_a_nxt),
        .o_qm (w_qm_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = (divisor == '0) ? StSign : StIter;
                end
            end
            StIter: begin
                if (r_cnt == CntLast) begin
                    w_state_d = StSign;
                end
            end
            StSign:  w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Status flags are registered from the current state, so they trail it by one edge.
    always_comb begin
        w_busy_d = (r_state == StIter) || (r_state == StSign);
        w_done_d = (r_state == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_qm       <= '0;
            r_m        <= '0;
            r_q_neg    <= 1'b0;
            r_m_neg    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_busy <= w_busy_d;
            r_done <= w_done_d;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_a        <= '0;
                        r_qm       <= magnitude(dividend);
                        r_m        <= magnitude(divisor);
                        r_q_neg    <= dividend[WIDTH-1];
                        r_m_neg    <= divisor[WIDTH-1];
                        r_ovf_pend <= (dividend == MinVal) && (divisor == '1);
                        r_dz       <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                StIter: begin
                    r_a   <= w_a_nxt;
                    r_qm  <= w_qm_nxt;
                    r_cnt <= r_cnt + CntW'(1);
                end
                StSign: begin
                    // Zero divisor skips iteration, so Qm still holds |dividend|.
                    if (r_m == '0) begin
                        r_quo <= '1;
                        r_rem <= r_q_neg ? -r_qm : r_qm;
                        r_dz  <= 1'b1;
                    end else begin
                        r_quo <= (r_q_neg ^ r_m_neg) ? -r_qm : r_qm;
                        r_rem <= r_q_neg ? -r_a : r_a;
                        r_ovf <= r_ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_restoring_div_seq_ctrl.sv
// Scoreboard bench for restoring_div_seq_ctrl: directed corner cases plus random operands,
// expected results from integer truncating division, checked by an independent done monitor.
module tb_restoring_div_seq_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dz;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    restoring_div_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Truncating signed division; the remainder takes the dividend's sign.
    function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] m);
        exp_t e;
        int   qi;
        int   mi;
        qi    = int'($signed(q));
        mi    = int'($signed(m));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.cyc = 0;
        if (mi == 0) begin
            e.quo = '1;
            e.rem = q;
            e.dz  = 1'b1;
        end else if (qi == -(2 ** (W - 1)) && mi == -1) begin
            e.quo = W'(qi);
            e.rem = '0;
            e.ovf = 1'b1;
        end else begin
            e.quo = W'(qi / mi);
            e.rem = W'(qi % mi);
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending result",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", 64'(quotient), 64'(e.quo));
                chk("remainder", 64'(remainder), 64'(e.rem));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // roff: if nonzero, re-pulse start with (q2, m2) so it is sampled on edge k+roff.
    task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] m, input int roff,
                         input logic [W-1:0] q2, input logic [W-1:0] m2);
        exp_t e;
        int   lat;
        int   kcyc;
        lat = (m == '0) ? 2 : W + 2;
        @(negedge clk);
        dividend = q;
        divisor  = m;
        start    = 1'b1;
        @(posedge clk);
        #1;
        kcyc     = cyc;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        e        = model(q, m);
        e.cyc    = kcyc + lat;
        sb.push_back(e);
        for (int i = 1; i <= lat + 1; i++) begin
            if (i == roff) begin
                dividend = q2;
                divisor  = m2;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("busy", 64'(busy), 64'(i <= lat - 1));
        end
        chk("result_seen", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] m;
        int           r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        do_op(8'd100, 8'd7, 0, 8'd0, 8'd0);
        do_op(-8'sd100, 8'd7, 0, 8'd0, 8'd0);
        do_op(8'd100, -8'sd7, 0, 8'd0, 8'd0);
        do_op(-8'sd100, -8'sd7, 0, 8'd0, 8'd0);
        do_op(8'h80, 8'hFF, 0, 8'd0, 8'd0);
        do_op(8'h80, 8'h01, 0, 8'd0, 8'd0);
        do_op(8'd127, 8'd127, 0, 8'd0, 8'd0);
        do_op(8'd55, 8'd0, 0, 8'd0, 8'd0);
        do_op(8'h80, 8'd0, 0, 8'd0, 8'd0);
        // Start re-pulsed mid-iteration and during the DONE state must be ignored.
        do_op(8'd100, 8'd7, 3, 8'd20, 8'd3);
        do_op(8'd77, 8'd5, W + 2, 8'd9, 8'd2);
        do_op(8'd55, 8'd0, 2, 8'd9, 8'd2);

        // Abort after four iterations: outputs clear, no done may appear afterwards.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_quotient", 64'(quotient), 64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        chk("abort_div_by_zero", 64'(div_by_zero), 64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        repeat (15) @(negedge clk);
        do_op(8'd9, 8'd2, 0, 8'd0, 8'd0);

        for (int n = 0; n < 80; n++) begin
            q = W'($urandom);
            m = W'($urandom);
            r = $urandom_range(0, 15);
            if (r == 0) begin
                m = '0;
            end else if (r == 1) begin
                q = 8'h80;
                m = 8'hFF;
            end else if (r == 2) begin
                m = W'($urandom_range(1, 4));
            end
            do_op(q, m, 0, 8'd0, 8'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
